// File: rtl/data_cache_dm.sv
// data_cache_dm: direct-mapped, write-back, write-allocate data cache with
// one-word lines. A five-state miss handler serialises victim write-back and
// line fill over a single memory request channel. All outputs are registered.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module data_cache_dm #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned SETS   = 128,
    parameter int unsigned STAT_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_hit,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_rw,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_rdata
`ifdef DCACHE_STATS_EN
    ,
    output logic [STAT_W-1:0] hit_count,
    output logic [STAT_W-1:0] miss_count
`endif
);

    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = ADDR_W - IDX_W;

    if (SETS < 2 || (SETS & (SETS - 1)) != 0 || SETS >= (1 << ADDR_W) || STAT_W < 1) begin : g_bad_params
        $error("data_cache_dm: SETS must be a power of two in [2, 2**ADDR_W) and STAT_W >= 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WRITEBACK,
        FILL_REQ,
        FILL_WAIT
    } state_t;

    state_t            state_q;
    logic              rw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    // Line state: valid/dirty are reset, data/tag are not.
    logic [SETS-1:0]   valid_q;
    logic [SETS-1:0]   dirty_q;
    logic [DATA_W-1:0] data_q [SETS];
    logic [TAG_W-1:0]  tag_q  [SETS];

    logic              req_ready_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_hit_q;
    logic              mem_req_valid_q;
    logic              mem_req_rw_q;
    logic [ADDR_W-1:0] mem_req_addr_q;
    logic [DATA_W-1:0] mem_req_wdata_q;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  req_tag;
    logic [DATA_W-1:0] line_data;
    logic [TAG_W-1:0]  line_tag;
    logic              line_hit;
    logic              victim_dirty;
    logic              line_we;
    logic [DATA_W-1:0] line_wdata_d;

    assign idx          = addr_q[IDX_W-1:0];
    assign req_tag      = addr_q[ADDR_W-1:IDX_W];
    assign line_data    = data_q[idx];
    assign line_tag     = tag_q[idx];
    assign line_hit     = valid_q[idx] && (line_tag == req_tag);
    assign victim_dirty = valid_q[idx] && dirty_q[idx];

    // Data/tag write port: write hit, write install (direct or after write-back), fill.
    always_comb begin
        line_we      = 1'b0;
        line_wdata_d = wdata_q;
        unique case (state_q)
            LOOKUP:    line_we = rw_q && (line_hit || !victim_dirty);
            WRITEBACK: line_we = rw_q && mem_req_ready;
            FILL_WAIT: begin
                line_we      = mem_rsp_valid;
                line_wdata_d = mem_rsp_rdata;
            end
            default:   line_we = 1'b0;
        endcase
    end

    // Data and tag arrays carry no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (line_we) begin
            data_q[idx] <= line_wdata_d;
            tag_q[idx]  <= req_tag;
        end
    end

    // Miss-handling FSM with registered core and memory outputs and line flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            rw_q            <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            valid_q         <= '0;
            dirty_q         <= '0;
            req_ready_q     <= 1'b0;
            rsp_valid_q     <= 1'b0;
            rsp_rdata_q     <= '0;
            rsp_hit_q       <= 1'b0;
            mem_req_valid_q <= 1'b0;
            mem_req_rw_q    <= 1'b0;
            mem_req_addr_q  <= '0;
            mem_req_wdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        rw_q        <= req_rw;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        req_ready_q <= 1'b0;
                        state_q     <= LOOKUP;
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                LOOKUP: begin
                    if (line_hit) begin
                        if (rw_q) dirty_q[idx] <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= rw_q ? wdata_q : line_data;
                        rsp_hit_q   <= 1'b1;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end else if (victim_dirty) begin
                        mem_req_valid_q <= 1'b1;
                        mem_req_rw_q    <= 1'b1;
                        mem_req_addr_q  <= {line_tag, idx};
                        mem_req_wdata_q <= line_data;
                        state_q         <= WRITEBACK;
                    end else if (rw_q) begin
                        valid_q[idx] <= 1'b1;
                        dirty_q[idx] <= 1'b1;
                        rsp_valid_q  <= 1'b1;
                        rsp_rdata_q  <= wdata_q;
                        rsp_hit_q    <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= IDLE;
                    end else begin
                        mem_req_valid_q <= 1'b1;
                        mem_req_rw_q    <= 1'b0;
                        mem_req_addr_q  <= addr_q;
                        state_q         <= FILL_REQ;
                    end
                end
                WRITEBACK: begin
                    if (mem_req_ready) begin
                        if (rw_q) begin
                            // Write-back done; the write installs and the line is dirty again.
                            valid_q[idx]    <= 1'b1;
                            dirty_q[idx]    <= 1'b1;
                            mem_req_valid_q <= 1'b0;
                            rsp_valid_q     <= 1'b1;
                            rsp_rdata_q     <= wdata_q;
                            rsp_hit_q       <= 1'b0;
                            req_ready_q     <= 1'b1;
                            state_q         <= IDLE;
                        end else begin
                            dirty_q[idx]    <= 1'b0;
                            mem_req_rw_q    <= 1'b0;
                            mem_req_addr_q  <= addr_q;
                            state_q         <= FILL_REQ;
                        end
                    end
                end
                FILL_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        state_q         <= FILL_WAIT;
                    end
                end
                FILL_WAIT: begin
                    if (mem_rsp_valid) begin
                        valid_q[idx] <= 1'b1;
                        dirty_q[idx] <= 1'b0;
                        rsp_valid_q  <= 1'b1;
                        rsp_rdata_q  <= mem_rsp_rdata;
                        rsp_hit_q    <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready     = req_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_hit       = rsp_hit_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_rw    = mem_req_rw_q;
    assign mem_req_addr  = mem_req_addr_q;
    assign mem_req_wdata = mem_req_wdata_q;

`ifdef DCACHE_STATS_EN
    logic [STAT_W-1:0] hit_cnt_q;
    logic [STAT_W-1:0] miss_cnt_q;

    // Saturating hit/miss counters, one step per presented response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (rsp_valid_q) begin
            if (rsp_hit_q) begin
                if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + STAT_W'(1);
            end else begin
                if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + STAT_W'(1);
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_data_cache_dm.sv
// Directed scoreboard bench for data_cache_dm: expected core responses and
// memory requests are queued as stimulus is issued and popped as the DUT
// produces them. A memory responder supplies fills and backpressure.
module tb_data_cache_dm;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 8;
    localparam int SETS   = 128;
`ifdef DCACHE_STATS_EN
    localparam int STAT_W = 2;
`else
    localparam int STAT_W = 16;
`endif

    logic              clk;
    logic              reset_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_rw;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_hit;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_rw;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rsp_rdata;
`ifdef DCACHE_STATS_EN
    logic [STAT_W-1:0] hit_count;
    logic [STAT_W-1:0] miss_count;
`endif

    data_cache_dm #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .SETS  (SETS),
        .STAT_W(STAT_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_rw       (req_rw),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_hit      (rsp_hit),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_rw   (mem_req_rw),
        .mem_req_addr (mem_req_addr),
        .mem_req_wdata(mem_req_wdata),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_rdata(mem_rsp_rdata)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count    (hit_count),
        .miss_count   (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic              hit;
    } rsp_t;

    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mreq_t;

    rsp_t  rsp_q[$];
    mreq_t mq[$];
    int    checks = 0;
    int    errors = 0;

    logic [DATA_W-1:0] mem_model [512];
    int                stall_left = 0;
    bit                stray      = 1'b0;
    bit                hold_fill  = 1'b0;
    bit                fill_seen  = 1'b0;
    bit                cap_ok     = 1'b0;
    int                fill_cnt   = 0;
    int                mem_acc    = 0;
    logic [ADDR_W-1:0] fill_addr;
    logic              cap_rw;
    logic [ADDR_W-1:0] cap_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic exp_mem(input logic rw, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd);
        mreq_t m;
        m.rw = rw; m.addr = addr; m.wdata = wd;
        mq.push_back(m);
    endtask

    // Issue one core request; optionally queue its expected response and wait for it.
    task automatic access(input logic rw, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd,
                          input bit exp_rsp, input logic [DATA_W-1:0] exp_rdata, input logic exp_hit,
                          output int lat);
        rsp_t r;
        int   waited;
        if (exp_rsp) begin
            r.rdata = exp_rdata; r.hit = exp_hit;
            rsp_q.push_back(r);
        end
        @(negedge clk);
        req_valid = 1'b1; req_rw = rw; req_addr = addr; req_wdata = wd;
        waited = 0;
        while (!req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("req_accept", req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        if (exp_rsp) begin
            while (!rsp_valid && lat < 200) begin
                @(negedge clk);
                lat++;
            end
            chk("rsp_arrived", rsp_valid, 1);
        end
    endtask

    // Response scoreboard.
    always @(negedge clk) begin
        rsp_t e;
        if (reset_n && rsp_valid) begin
            chk("rsp_expected", rsp_q.size() != 0, 1);
            if (rsp_q.size() != 0) begin
                e = rsp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_hit", rsp_hit, e.hit);
            end
        end
    end

    // Memory responder: decides ready at the falling edge, so a request seen
    // here with ready raised is accepted at the following rising edge.
    initial begin
        mreq_t e;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = '0;
        forever begin
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            if (!reset_n) begin
                mem_req_ready = 1'b0;
                fill_cnt      = 0;
                cap_ok        = 1'b0;
            end else begin
                if (fill_cnt > 0) begin
                    fill_cnt--;
                    if (fill_cnt == 0) begin
                        mem_rsp_valid = 1'b1;
                        mem_rsp_rdata = mem_model[fill_addr];
                    end
                end
                if (mem_req_valid && stall_left > 0) begin
                    mem_req_ready = 1'b0;
                    if (!cap_ok) begin
                        cap_ok   = 1'b1;
                        cap_rw   = mem_req_rw;
                        cap_addr = mem_req_addr;
                    end else begin
                        chk("bp_stable", {mem_req_valid, mem_req_rw, mem_req_addr}, {1'b1, cap_rw, cap_addr});
                    end
                    stall_left--;
                    if (stray && !mem_rsp_valid) begin
                        mem_rsp_valid = 1'b1;
                        mem_rsp_rdata = 8'hEE;
                    end
                end else if (mem_req_valid) begin
                    mem_req_ready = 1'b1;
                    mem_acc++;
                    if (cap_ok) begin
                        chk("bp_stable_accept", {mem_req_valid, mem_req_rw, mem_req_addr}, {1'b1, cap_rw, cap_addr});
                        cap_ok = 1'b0;
                    end
                    chk("mem_req_expected", mq.size() != 0, 1);
                    if (mq.size() != 0) begin
                        e = mq.pop_front();
                        chk("mem_req_rw", mem_req_rw, e.rw);
                        chk("mem_req_addr", mem_req_addr, e.addr);
                        if (e.rw) chk("mem_req_wdata", mem_req_wdata, e.wdata);
                    end
                    if (mem_req_rw) begin
                        mem_model[mem_req_addr] = mem_req_wdata;
                    end else begin
                        fill_seen = 1'b1;
                        if (!hold_fill) begin
                            fill_addr = mem_req_addr;
                            fill_cnt  = 2;
                        end
                    end
                end else begin
                    mem_req_ready = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int acc0;
        req_valid = 1'b0; req_rw = 1'b0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 512; i++) mem_model[i] = '0;
        mem_model[9'h005] = 8'hA5;
        mem_model[9'h085] = 8'h77;
        mem_model[9'h123] = 8'h42;
        mem_model[9'h040] = 8'h99;
        mem_model[9'h041] = 8'h11;
        reset_n = 1'b0;

        #12;
        chk("reset_req_ready", req_ready, 0);
        chk("reset_rsp", {rsp_valid, rsp_hit, rsp_rdata}, 0);
        chk("reset_mem_req", {mem_req_valid, mem_req_rw, mem_req_addr, mem_req_wdata}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1 chk("ready_after_release", req_ready, 1);

        // Read miss then hit
        exp_mem(1'b0, 9'h005, 8'h00);
        access(1'b0, 9'h005, 8'h00, 1, 8'hA5, 1'b0, lat);
        acc0 = mem_acc;
        access(1'b0, 9'h005, 8'h00, 1, 8'hA5, 1'b1, lat);
        chk("read_hit_latency", lat, 2);
        chk("read_hit_no_mem", mem_acc - acc0, 0);

        // Dirty eviction
        access(1'b1, 9'h005, 8'h3C, 1, 8'h3C, 1'b1, lat);
        chk("write_hit_latency", lat, 2);
        exp_mem(1'b1, 9'h005, 8'h3C);
        exp_mem(1'b0, 9'h085, 8'h00);
        access(1'b0, 9'h085, 8'h00, 1, 8'h77, 1'b0, lat);
        acc0 = mem_acc;
        exp_mem(1'b0, 9'h005, 8'h00);
        access(1'b0, 9'h005, 8'h00, 1, 8'h3C, 1'b0, lat);
        chk("clean_evict_one_req", mem_acc - acc0, 1);

        // Write miss to a clean set
        acc0 = mem_acc;
        access(1'b1, 9'h100, 8'h5A, 1, 8'h5A, 1'b0, lat);
        chk("write_miss_latency", lat, 2);
        chk("write_miss_no_mem", mem_acc - acc0, 0);
        access(1'b0, 9'h100, 8'h00, 1, 8'h5A, 1'b1, lat);

        // Memory backpressure with a stray fill response
        stall_left = 5;
        stray      = 1'b1;
        exp_mem(1'b0, 9'h123, 8'h00);
        access(1'b0, 9'h123, 8'h00, 1, 8'h42, 1'b0, lat);
        stray = 1'b0;
        chk("bp_stall_consumed", stall_left, 0);

        // Reset during FILL_WAIT
        hold_fill = 1'b1;
        fill_seen = 1'b0;
        exp_mem(1'b0, 9'h040, 8'h00);
        access(1'b0, 9'h040, 8'h00, 0, 8'h00, 1'b0, lat);
        for (int i = 0; i < 50 && !fill_seen; i++) @(negedge clk);
        chk("fill_accepted", fill_seen, 1);
        @(negedge clk);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("midreset_req_ready", req_ready, 0);
        chk("midreset_rsp", {rsp_valid, rsp_hit, rsp_rdata}, 0);
        chk("midreset_mem_req", {mem_req_valid, mem_req_rw, mem_req_addr, mem_req_wdata}, 0);
`ifdef DCACHE_STATS_EN
        chk("midreset_counters", {hit_count, miss_count}, 0);
`endif
        @(negedge clk);
        #2 reset_n = 1'b1;
        hold_fill = 1'b0;
        @(posedge clk);
        #1 chk("ready_after_midreset", req_ready, 1);
        exp_mem(1'b0, 9'h040, 8'h00);
        access(1'b0, 9'h040, 8'h00, 1, 8'h99, 1'b0, lat);

        // Three hits and a second miss since the last reset
        for (int i = 0; i < 3; i++) access(1'b0, 9'h040, 8'h00, 1, 8'h99, 1'b1, lat);
        exp_mem(1'b0, 9'h041, 8'h00);
        access(1'b0, 9'h041, 8'h00, 1, 8'h11, 1'b0, lat);
        @(negedge clk);
`ifdef DCACHE_STATS_EN
        chk("hit_count", hit_count, 3);
        chk("miss_count", miss_count, 2);
`endif
        // One more hit with the hit counter already at its maximum
        access(1'b0, 9'h040, 8'h00, 1, 8'h99, 1'b1, lat);
        @(negedge clk);
`ifdef DCACHE_STATS_EN
        chk("hit_count_saturated", hit_count, 3);
        chk("miss_count_held", miss_count, 2);
`endif

        repeat (3) @(negedge clk);
        chk("rsp_queue_drained", rsp_q.size(), 0);
        chk("mem_queue_drained", mq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_cache_dm.md
# data_cache_dm

Parametrised direct-mapped, write-back, write-allocate data cache with valid/dirty tracking and a miss-handling state machine. It sits between the core load/store port and the backing data memory. Valid/ready handshakes run on both sides, and victim write-back and line fill go over a single memory request channel. Lines are one word wide.

## Interface
- `ADDR_W`, default 9: request address width in word addresses.
- `DATA_W`, default 8: word width.
- `SETS`, default 128: number of lines. Must be a power of two, at least 2, and less than `2**ADDR_W`.
- `IDX_W = $clog2(SETS)` and `TAG_W = ADDR_W-IDX_W`: derived local parameters, not overridable.
- `STAT_W`, default 16: counter width. Used only with `DCACHE_STATS_EN`.

Ports:
- `clk`, in, 1: the single clock. All state changes on the rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `req_valid`, in, 1: core request present.
- `req_ready`, out, 1: cache can accept a request.
- `req_rw`, in, 1: 1 = write, 0 = read.
- `req_addr`, in, `ADDR_W`: word address.
- `req_wdata`, in, `DATA_W`: write data.
- `rsp_valid`, out, 1: one-cycle response pulse. There is no backpressure on this channel.
- `rsp_rdata`, out, `DATA_W`: read data, or the written data for writes.
- `rsp_hit`, out, 1: 1 if the request hit in the cache.
- `mem_req_valid`, out, 1: memory request present.
- `mem_req_ready`, in, 1: memory accepts the request.
- `mem_req_rw`, out, 1: 1 = write-back, 0 = fill read.
- `mem_req_addr`, out, `ADDR_W`: memory word address.
- `mem_req_wdata`, out, `DATA_W`: victim data.
- `mem_rsp_valid`, in, 1: fill data present. Ignored outside `FILL_WAIT`.
- `mem_rsp_rdata`, in, `DATA_W`: fill data.
- `hit_count`, out, `STAT_W`: present only with `DCACHE_STATS_EN`.
- `miss_count`, out, `STAT_W`: present only with `DCACHE_STATS_EN`.

## Operation
- Address split: index = `req_addr[IDX_W-1:0]`, tag = `req_addr[ADDR_W-1:IDX_W]`.
- Per-line state is `data[DATA_W]`, `tag[TAG_W]`, `valid` and `dirty`.
- Only `valid` and `dirty` are reset. The data and tag arrays are not reset.
- FSM states: `IDLE`, `LOOKUP`, `WRITEBACK`, `FILL_REQ`, `FILL_WAIT`.
- `IDLE`:
  - `req_ready`=1 in this state only.
  - A request is accepted when `req_valid && req_ready`; the cache then latches rw, addr and wdata and moves to `LOOKUP`.
- `LOOKUP`: hit is `valid[idx] && tag[idx]==req_tag`.
  - Read hit: `rsp_rdata`=`data[idx]`, `rsp_hit`=1, then `IDLE`.
  - Write hit: `data[idx]`=wdata, `dirty[idx]`=1, `rsp_rdata`=wdata, `rsp_hit`=1, then `IDLE`.
  - Miss with a valid and dirty victim: go to `WRITEBACK`.
  - Miss with a clean or invalid victim: reads go to `FILL_REQ`. Writes install the line directly with no fill (single-word line): data=wdata, tag=req_tag, valid=1, dirty=1, `rsp_hit`=0, then `IDLE`.
- `WRITEBACK`:
  - Drives `mem_req_valid`=1, rw=1, addr=`{tag[idx],idx}`, wdata=`data[idx]`.
  - On `mem_req_ready`, `dirty[idx]` is cleared. Reads then go to `FILL_REQ`; writes install the line as described for a clean miss and go to `IDLE`.
- `FILL_REQ`:
  - Drives `mem_req_valid`=1, rw=0, addr=`req_addr`.
  - On `mem_req_ready`, go to `FILL_WAIT`.
- `FILL_WAIT`:
  - Waits for `mem_rsp_valid`.
  - Then data=`mem_rsp_rdata`, tag=req_tag, valid=1, dirty=0.
  - Response: `rsp_rdata`=`mem_rsp_rdata`, `rsp_hit`=0, then `IDLE`.
- Write-back is never followed by a memory response; the memory does not return one for writes.
- While `mem_req_valid`=1 and `mem_req_ready`=0, all `mem_req_*` outputs are held stable. A request is never withdrawn.
- Back-to-back requests to the same index see the update made by the previous request.

## Timing
- All outputs are registered.
- Reset values: `req_ready`=0 during reset and 1 in the first cycle after release; `rsp_valid`=0, `rsp_rdata`=0, `rsp_hit`=0; all `mem_req_*`=0; counters=0. State = `IDLE`.
- Hit latency: accept at edge E0, lookup at E1, `rsp_valid` high for the cycle after E1. `req_ready` is high in that same cycle, so the hit throughput is one request per 2 cycles.
- Clean read miss: `mem_req_valid` rises in the cycle after E1. `rsp_valid` pulses in the cycle after the edge that samples `mem_rsp_valid`.
- Dirty read miss: `WRITEBACK` runs first. `FILL_REQ` starts the cycle after write-back acceptance.
- Write miss: response in the cycle after E1 (clean victim) or after write-back acceptance (dirty victim).
- Reset assertion mid-operation: the FSM returns to `IDLE` immediately; `mem_req_valid` and `rsp_valid` drop asynchronously. Pending requests and dirty data are lost; the owner of the memory side handles this.

## Configuration
- `DCACHE_STATS_EN` defined: adds the `hit_count` and `miss_count` ports.
  - Each counter increments once per completed response according to `rsp_hit`.
  - Counters saturate at `2**STAT_W-1` and are cleared by `reset_n`.
- `DCACHE_STATS_EN` undefined: the counter ports and logic are absent. All other behaviour is identical.

## Test plan
Defaults for all scenarios: `ADDR_W`=9, `DATA_W`=8, `SETS`=128.
- Read miss then hit:
  - Stimulus: after reset, read 0x005; memory replies 0xA5.
  - Required: `mem_req` rw=0, addr=0x005; response `rsp_rdata`=0xA5 with `rsp_hit`=0.
  - Stimulus: read 0x005 again.
  - Required: `rsp_hit`=1, `rsp_rdata`=0xA5, `rsp_valid` 2 cycles after accept, no memory traffic.
- Dirty eviction:
  - Stimulus: write 0x005=0x3C (hit), then read 0x085; memory replies 0x77.
  - Required: memory write addr=0x005, data=0x3C, followed by memory read addr=0x085; `rsp_rdata`=0x77 with `rsp_hit`=0.
  - Stimulus: read 0x005.
  - Required: miss, with the fill read issued and no write-back.
- Write miss to a clean set:
  - Stimulus: write 0x100=0x5A.
  - Required: no `mem_req_valid`; `rsp_hit`=0.
  - Stimulus: read 0x100.
  - Required: `rsp_hit`=1, `rsp_rdata`=0x5A.
- Memory backpressure:
  - Stimulus: hold `mem_req_ready`=0 for 5 cycles during the fill.
  - Required: `mem_req_valid`, addr and rw stable for all 5 cycles. A stray `mem_rsp_valid` during `FILL_REQ` is ignored.
- Reset during `FILL_WAIT`:
  - Stimulus: pulse `reset_n` low.
  - Required: all outputs return to their reset values immediately.
  - Stimulus: after release, read the same address.
  - Required: miss with a new fill request.
- Stats (`DCACHE_STATS_EN` defined):
  - Stimulus: 3 hits and 2 misses.
  - Required: `hit_count`=3, `miss_count`=2.
  - Stimulus: preload the counter to `2**STAT_W-1` and record one more event.
  - Required: the counter stays at `2**STAT_W-1`.
